spill_buffer_flushable: RTL and testbench

- Parametrised successor of the two-entry flushable spill register: a Depth-entry elastic buffer with valid/ready handshakes on both sides.
- Cuts every combinational path from input to output and from ready_i to ready_o.
- Adds configurable depth, an occupancy output, and a defined flush-versus-input policy, so flush and valid can legally coincide.
- Placed on long interconnect paths and between pipeline stages that need a flush, for example a squash after a mispredict or abort.

---
 rtl/spill_buffer_flushable.sv | 97 +++++++++
 tb/tb_spill_buffer_flushable.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/spill_buffer_flushable.sv
// Depth-entry elastic buffer with valid/ready on both sides and a flush input.
// Downstream valid/data and upstream ready come from registers; only flush_i reaches ready_o.
module spill_buffer_flushable #(
  parameter type         T                 = logic,
  parameter int unsigned Depth             = 2,
  parameter bit          Bypass            = 1'b0,
  parameter bit          FlushAcceptsInput = 1'b0,
  parameter int unsigned UsageWidth        = $clog2(Depth + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  T                      data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output T                      data_o,
  output logic [UsageWidth-1:0] usage_o
);

  if (Depth < 1) begin : g_depth_check
    $error("spill_buffer_flushable: Depth must be at least 1");
  end

  if (Bypass) begin : g_bypass
    logic w_unused;
    assign w_unused = ^{clk_i, rst_i, flush_i};

    assign valid_o = valid_i;
    assign ready_o = ready_i;
    assign data_o  = data_i;
    assign usage_o = '0;
  end else begin : g_buffer
    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

    T                      r_mem [Depth];
    logic [PtrWidth-1:0]   r_rd_ptr;
    logic [PtrWidth-1:0]   r_wr_ptr;
    logic [UsageWidth-1:0] r_count;

    logic w_valid;
    logic w_ready;
    logic w_push;
    logic w_pop;

    // Explicit wrap so non-power-of-two depths stay in range.
    function automatic logic [PtrWidth-1:0] f_next(input logic [PtrWidth-1:0] ptr);
      if (ptr == PtrWidth'(Depth - 1)) begin
        return '0;
      end
      return ptr + PtrWidth'(1);
    endfunction

    assign w_valid = (r_count != '0);
    assign w_ready = flush_i ? FlushAcceptsInput : (r_count != UsageWidth'(Depth));
    assign w_push  = valid_i && w_ready;
    assign w_pop   = w_valid && ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int unsigned i = 0; i < Depth; i++) begin
          r_mem[i] <= '0;
        end
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else if (flush_i) begin
        // A flush restarts the ring at slot 0, optionally holding the concurrent beat.
        r_rd_ptr <= '0;
        if (w_push) begin
          r_mem[0] <= data_i;
          r_wr_ptr <= f_next('0);
          r_count  <= UsageWidth'(1);
        end else begin
          r_wr_ptr <= '0;
          r_count  <= '0;
        end
      end else begin
        if (w_push) begin
          r_mem[r_wr_ptr] <= data_i;
          r_wr_ptr        <= f_next(r_wr_ptr);
        end
        if (w_pop) begin
          r_rd_ptr <= f_next(r_rd_ptr);
        end
        r_count <= r_count + UsageWidth'(w_push) - UsageWidth'(w_pop);
      end
    end

    assign valid_o = w_valid;
    assign ready_o = w_ready;
    assign data_o  = r_mem[r_rd_ptr];
    assign usage_o = r_count;
  end

endmodule

// File: tb/tb_spill_buffer_flushable.sv
// Randomized and directed bench for spill_buffer_flushable: four buffered variants plus a
// bypass instance share one stimulus stream and are scored against per-instance FIFO models.
module tb_spill_buffer_flushable;

  localparam int unsigned NDut = 4;
  localparam int unsigned DEP [NDut] = '{4, 4, 3, 1};
  localparam bit          FAI [NDut] = '{1'b0, 1'b1, 1'b0, 1'b1};

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       flush_i;
  logic       valid_i;
  logic       ready_i;
  logic [7:0] data_i;

  wire [NDut-1:0]      vout;
  wire [NDut-1:0]      rout;
  wire [NDut-1:0][7:0] dout;
  wire [2:0]           u0, u1;
  wire [1:0]           u2;
  wire [0:0]           u3;
  wire [2:0]           usg [NDut];
  wire                 vb, rb;
  wire [7:0]           db;
  wire [1:0]           ub;

  assign usg[0] = u0;
  assign usg[1] = u1;
  assign usg[2] = {1'b0, u2};
  assign usg[3] = {2'b0, u3};

  int n_checks = 0;
  int n_errors = 0;
  int acc2     = 0;
  int pop2     = 0;

  logic [7:0]  mq   [NDut][4];
  int unsigned mcnt [NDut];

  always #5 clk_i = ~clk_i;

  spill_buffer_flushable #(.T(logic [7:0]), .Depth(4), .FlushAcceptsInput(1'b0)) u_d0 (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(rout[0]),
    .data_i(data_i), .valid_o(vout[0]), .ready_i(ready_i), .data_o(dout[0]), .usage_o(u0));

  spill_buffer_flushable #(.T(logic [7:0]), .Depth(4), .FlushAcceptsInput(1'b1)) u_d1 (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(rout[1]),
    .data_i(data_i), .valid_o(vout[1]), .ready_i(ready_i), .data_o(dout[1]), .usage_o(u1));

  spill_buffer_flushable #(.T(logic [7:0]), .Depth(3), .FlushAcceptsInput(1'b0)) u_d2 (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(rout[2]),
    .data_i(data_i), .valid_o(vout[2]), .ready_i(ready_i), .data_o(dout[2]), .usage_o(u2));

  spill_buffer_flushable #(.T(logic [7:0]), .Depth(1), .FlushAcceptsInput(1'b1)) u_d3 (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(rout[3]),
    .data_i(data_i), .valid_o(vout[3]), .ready_i(ready_i), .data_o(dout[3]), .usage_o(u3));

  spill_buffer_flushable #(.T(logic [7:0]), .Depth(2), .Bypass(1'b1)) u_byp (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(rb),
    .data_i(data_i), .valid_o(vb), .ready_i(ready_i), .data_o(db), .usage_o(ub));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NDut; k++) begin
      mcnt[k] = 0;
    end
  endtask

  // One clock: score every instance at the falling edge, advance the models, resume after the rising edge.
  task automatic step();
    logic exp_val, exp_rdy, push, pop;
    @(negedge clk_i);
    check("byp_valid", 32'(vb), 32'(valid_i));
    check("byp_ready", 32'(rb), 32'(ready_i));
    check("byp_data",  32'(db), 32'(data_i));
    check("byp_usage", 32'(ub), 32'(0));
    for (int k = 0; k < NDut; k++) begin
      exp_val = (mcnt[k] != 0);
      exp_rdy = flush_i ? FAI[k] : (mcnt[k] != DEP[k]);
      check($sformatf("d%0d_ready", k), 32'(rout[k]), 32'(exp_rdy));
      check($sformatf("d%0d_valid", k), 32'(vout[k]), 32'(exp_val));
      check($sformatf("d%0d_usage", k), 32'(usg[k]), 32'(mcnt[k]));
      if (exp_val) begin
        check($sformatf("d%0d_data", k), 32'(dout[k]), 32'(mq[k][0]));
      end
      if (!rst_i) begin
        push = valid_i && exp_rdy;
        pop  = exp_val && ready_i;
        if (k == 2 && push) acc2++;
        if (k == 2 && pop)  pop2++;
        if (flush_i) begin
          mcnt[k] = 0;
          if (push) begin
            mq[k][0] = data_i;
            mcnt[k]  = 1;
          end
        end else begin
          if (pop) begin
            for (int j = 0; j < 3; j++) mq[k][j] = mq[k][j + 1];
            mcnt[k]--;
          end
          if (push) begin
            mq[k][mcnt[k]] = data_i;
            mcnt[k]++;
          end
        end
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic f);
    valid_i = v;
    data_i  = d;
    ready_i = r;
    flush_i = f;
  endtask

  initial begin
    rst_i = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    model_clear();
    step();
    step();
    rst_i = 1'b0;
    step();

    // Streaming with a ready sink.
    drive(1'b1, 8'h11, 1'b1, 1'b0); step();
    drive(1'b1, 8'h22, 1'b1, 1'b0); step();
    drive(1'b1, 8'h33, 1'b1, 1'b0); step();
    drive(1'b0, 8'h00, 1'b1, 1'b0); step(); step();

    // Fill against a stalled sink, then drain past the pointer wrap.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
      step();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'(8'hB0 + i), 1'b1, 1'b0);
      step();
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0); step(); step(); step(); step();

    // Flush with a concurrent beat while partly filled.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'h01 + i), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 8'h55, 1'b0, 1'b1); step();
    drive(1'b1, 8'h55, 1'b0, 1'b0); step();
    drive(1'b0, 8'h00, 1'b1, 1'b0); step(); step(); step();

    // Flush while full with a sink that also pops.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 8'h77, 1'b1, 1'b1); step();
    drive(1'b0, 8'h00, 1'b1, 1'b0); step(); step(); step();

    // Depth-3 instance: 20 beats with a toggling sink.
    acc2 = 0;
    pop2 = 0;
    for (int c = 0; c < 100 && pop2 < 20; c++) begin
      drive(acc2 < 20, 8'(acc2), (c % 2) == 0, 1'b0);
      step();
    end
    check("d2_beats_in",  32'(acc2), 32'(20));
    check("d2_beats_out", 32'(pop2), 32'(20));

    // Asynchronous reset with stored entries.
    drive(1'b1, 8'h61, 1'b0, 1'b0); step();
    drive(1'b1, 8'h62, 1'b0, 1'b0); step();
    #2 rst_i = 1'b1;
    #1;
    for (int k = 0; k < NDut; k++) begin
      check($sformatf("d%0d_async_valid", k), 32'(vout[k]), 32'(0));
      check($sformatf("d%0d_async_usage", k), 32'(usg[k]), 32'(0));
    end
    model_clear();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    rst_i = 1'b0;
    step(); step();

    // Bypass transparency without a clock edge.
    for (int i = 0; i < 5; i++) begin
      drive(1'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      #1;
      check("byp_comb_data",  32'(db), 32'(data_i));
      check("byp_comb_valid", 32'(vb), 32'(valid_i));
      check("byp_comb_ready", 32'(rb), 32'(ready_i));
    end
    @(posedge clk_i);
    #1;

    // Randomized traffic with occasional flushes.
    for (int c = 0; c < 2000; c++) begin
      drive(1'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
